cordic_vectoring: RTL and testbench

Iterative vectoring-mode CORDIC. It converts one I/Q sample (x, y) into magnitude and phase, doing one micro-rotation per clock. It is the inverse direction of the rotation-mode DDC CORDIC: that block rotates by a given angle, while this one recovers the angle and magnitude of a vector. It sits after the decimation chain for magnitude/phase detection and uses a valid/ready handshake on both sides.

---
 rtl/cordic_pkg.sv | 40 ++++
 rtl/cordic_vector_step.sv | 41 ++++
 rtl/cordic_vectoring.sv | 136 +++++++++++++
 tb/tb_cordic_vectoring.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, phase width, FSM encodings, gain.
// Pure constants and one constant function, no logic of its own.
// No handshake at this level.
package cordic_pkg;

  localparam int PHASE_W = 16;

  // Aggregate gain of 16 micro-rotations in Q16 (about 1.64676), for reference models
  localparam int CORDIC_GAIN_Q16 = 107922;

  // FSM encodings shared by the iterative CORDIC blocks
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // round(atan(2^-i) * 65536 / (2*pi)), full circle = 65536 LSB
  function automatic logic [PHASE_W-1:0] atan_lut(input logic [3:0] i);
    logic [PHASE_W-1:0] v;
    case (i)
      4'd0:    v = 16'd8192;
      4'd1:    v = 16'd4836;
      4'd2:    v = 16'd2555;
      4'd3:    v = 16'd1297;
      4'd4:    v = 16'd651;
      4'd5:    v = 16'd326;
      4'd6:    v = 16'd163;
      4'd7:    v = 16'd81;
      4'd8:    v = 16'd41;
      4'd9:    v = 16'd20;
      4'd10:   v = 16'd10;
      4'd11:   v = 16'd5;
      4'd12:   v = 16'd3;
      4'd13:   v = 16'd1;
      4'd14:   v = 16'd1;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_vector_step.sv
// One vectoring-mode micro-rotation: drives y toward zero, accumulates angle in z.
// Purely combinational, zero latency.
// No handshake; the owning FSM decides when results are captured.
module cordic_vector_step
  import cordic_pkg::*;
#(
  parameter int XW = 18
) (
  input  logic signed [XW-1:0]      i_x,
  input  logic signed [XW-1:0]      i_y,
  input  logic        [PHASE_W-1:0] i_z,
  input  logic        [3:0]         i_shift,
  input  logic        [PHASE_W-1:0] i_atan,
  output logic signed [XW-1:0]      o_x,
  output logic signed [XW-1:0]      o_y,
  output logic        [PHASE_W-1:0] o_z
);

  logic signed [XW-1:0] w_x_sh;
  logic signed [XW-1:0] w_y_sh;

  assign w_x_sh = i_x >>> i_shift;
  assign w_y_sh = i_y >>> i_shift;

  // Rotate clockwise when y is non-negative, counter-clockwise otherwise; z wraps mod 2^16
  always_comb begin
    o_x = i_x;
    o_y = i_y;
    o_z = i_z;
    if (!i_y[XW-1]) begin
      o_x = i_x + w_y_sh;
      o_y = i_y - w_x_sh;
      o_z = i_z + i_atan;
    end else begin
      o_x = i_x - w_y_sh;
      o_y = i_y + w_x_sh;
      o_z = i_z - i_atan;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: (x, y) -> magnitude (gain K uncompensated) and phase.
// Latency: result valid exactly STAGES edges after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 14
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  x_in,
  input  logic signed [WIDTH-1:0]  y_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [WIDTH:0]    magnitude,
  output logic        [PHASE_W-1:0] phase
);

  // Two guard bits: room for the negation of -2^(WIDTH-1) and for the K growth
  localparam int         XW        = WIDTH + 2;
  localparam logic [3:0] LAST_ITER = 4'(STAGES - 1);

  logic [1:0]           r_state;
  logic signed [XW-1:0] r_x;
  logic signed [XW-1:0] r_y;
  logic [PHASE_W-1:0]   r_z;
  logic [3:0]           r_iter;
  logic                 r_out_valid;
  logic [WIDTH:0]       r_mag;
  logic [PHASE_W-1:0]   r_phase;

  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;
  logic signed [XW-1:0] w_x_pre;
  logic signed [XW-1:0] w_y_pre;
  logic [PHASE_W-1:0]   w_z_pre;
  logic signed [XW-1:0] w_x_nxt;
  logic signed [XW-1:0] w_y_nxt;
  logic [PHASE_W-1:0]   w_z_nxt;
  logic [PHASE_W-1:0]   w_atan;

  // Sign-extend before any negation so the most negative input stays representable
  assign w_xs = {{2{x_in[WIDTH-1]}}, x_in};
  assign w_ys = {{2{y_in[WIDTH-1]}}, y_in};

  // Pre-rotate by +/-90 deg so the iterations start in the right half-plane (x >= 0)
  always_comb begin
    w_x_pre = w_xs;
    w_y_pre = w_ys;
    w_z_pre = '0;
    if (x_in[WIDTH-1]) begin
      if (!y_in[WIDTH-1]) begin
        w_x_pre = w_ys;
        w_y_pre = -w_xs;
        w_z_pre = 16'h4000;
      end else begin
        w_x_pre = -w_ys;
        w_y_pre = w_xs;
        w_z_pre = 16'hC000;
      end
    end
  end

  assign w_atan = atan_lut(r_iter);

  cordic_vector_step #(
    .XW (XW)
  ) u_step (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_iter),
    .i_atan  (w_atan),
    .o_x     (w_x_nxt),
    .o_y     (w_y_nxt),
    .o_z     (w_z_nxt)
  );

  // FSM, iteration counter and result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_iter      <= '0;
      r_out_valid <= 1'b0;
      r_mag       <= '0;
      r_phase     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= w_x_pre;
            r_y     <= w_y_pre;
            r_z     <= w_z_pre;
            r_iter  <= '0;
            r_state <= ITER;
          end
        end
        ITER: begin
          r_x    <= w_x_nxt;
          r_y    <= w_y_nxt;
          r_z    <= w_z_nxt;
          r_iter <= r_iter + 4'd1;
          if (r_iter == LAST_ITER) begin
            // x is non-negative here, so dropping the top guard bit is lossless
            r_mag       <= w_x_nxt[WIDTH:0];
            r_phase     <= w_z_nxt;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign magnitude = r_mag;
  assign phase     = r_phase;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring with hand-computed expected values.
// Checks reset state, latency, phase/magnitude accuracy, backpressure and mid-run reset.
module tb_cordic_vectoring;

  localparam int WIDTH  = 16;
  localparam int STAGES = 14;

  logic                    clock;
  logic                    reset_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH:0]          magnitude;
  logic [15:0]             phase;

  int n_cmp;
  int n_err;

  cordic_vectoring #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .magnitude (magnitude),
    .phase     (phase)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_phase(input string tag, input logic [15:0] exp, input int tol);
    logic signed [15:0] d;
    logic               ok;
    d  = phase - exp;
    ok = (int'(d) <= tol) && (int'(d) >= -tol);
    n_cmp++;
    assert (ok === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed phase=%0d expected=%0d +/-%0d", tag, $signed(phase), $signed(exp), tol);
    end
  endtask

  task automatic check_mag(input string tag, input int exp, input int tol);
    int  d;
    logic ok;
    d  = int'(magnitude) - exp;
    ok = (d <= tol) && (d >= -tol);
    n_cmp++;
    assert (ok === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed magnitude=%0d expected=%0d +/-%0d", tag, magnitude, exp, tol);
    end
  endtask

  // Present a sample and let it be accepted on the next edge
  task automatic accept_sample(input string tag, input int x, input int y);
    x_in     = WIDTH'(x);
    y_in     = WIDTH'(y);
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check({tag, "_ready_low_after_accept"}, int'(in_ready), 0);
  endtask

  // Wait the fixed latency; out_valid must rise exactly on edge STAGES
  task automatic wait_result(input string tag, input logic [15:0] exp_ph, input int ph_tol,
                             input int exp_mag, input int mag_tol);
    for (int k = 1; k <= STAGES; k++) begin
      @(posedge clock); #1;
      if (k == STAGES - 1) begin
        check({tag, "_valid_early"}, int'(out_valid), 0);
        check({tag, "_ready_busy"}, int'(in_ready), 0);
      end
    end
    check({tag, "_valid_on_time"}, int'(out_valid), 1);
    check_phase({tag, "_phase"}, exp_ph, ph_tol);
    if (mag_tol >= 0) check_mag({tag, "_mag"}, exp_mag, mag_tol);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({tag, "_valid_cleared"}, int'(out_valid), 0);
    check({tag, "_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;

    #2;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_magnitude", int'(magnitude), 0);
    check("reset_phase", int'(phase), 0);
    #20 reset_n = 1'b1;

    accept_sample("pos_x", 10000, 0);
    wait_result("pos_x", 16'd0, 2, 16468, 4);
    consume("pos_x");

    accept_sample("pos_y", 0, 10000);
    wait_result("pos_y", 16'd16384, 2, 16468, 4);
    consume("pos_y");

    accept_sample("diag45", 7071, 7071);
    wait_result("diag45", 16'd8192, 2, 16468, 6);
    consume("diag45");

    accept_sample("neg_x", -10000, 0);
    wait_result("neg_x", 16'h8000, 2, 16468, 4);
    consume("neg_x");

    accept_sample("neg_x_small_neg_y", -10000, -1);
    wait_result("neg_x_small_neg_y", 16'h8001, 2, 16468, 4);
    consume("neg_x_small_neg_y");

    accept_sample("min_min", -32768, -32768);
    wait_result("min_min", 16'hA000, 2, 76314, 8);
    consume("min_min");

    accept_sample("max_min", 32767, -32768);
    wait_result("max_min", 16'hE000, 2, 76312, 8);
    consume("max_min");

    accept_sample("zero", 0, 0);
    wait_result("zero", 16'd0, 32767, 0, 0);
    consume("zero");

    // Backpressure: hold the result, offer a new sample that must be ignored
    accept_sample("bp", 10000, 0);
    wait_result("bp", 16'd0, 2, 16468, 4);
    x_in     = 16'sd0;
    y_in     = 16'sd10000;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_ready", int'(in_ready), 0);
      check_phase("bp_hold_phase", 16'd0, 2);
      check_mag("bp_hold_mag", 16468, 4);
    end
    consume("bp_release");
    accept_sample("b2b", 0, 10000);
    wait_result("b2b", 16'd16384, 2, 16468, 4);
    consume("b2b");

    // Abort mid-iteration: reset clears everything at once
    accept_sample("abort", 7071, 7071);
    for (int k = 0; k < 5; k++) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort_valid", int'(out_valid), 0);
    check("abort_phase", int'(phase), 0);
    check("abort_mag", int'(magnitude), 0);
    check("abort_ready", int'(in_ready), 1);
    #10 reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_abort_ready", int'(in_ready), 1);
    accept_sample("post_abort", 7071, 7071);
    wait_result("post_abort", 16'd8192, 2, 16468, 6);
    consume("post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
